// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and 32 x 32-bit architectural register file.
// Selects the write-back value (link address, extracted load data or ALU
// result), commits it on the rising clock, and serves two combinational read
// ports to decode. Register 0 is hard-wired to zero.
// Optional feature macro: WB_BYPASS_EN -- when defined, a read of the register
// being written in the same cycle returns the write-back value directly.
module wb_regfile #(
    parameter int NREG    = 32,
    parameter int LINKOFS = 8
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        FINMEMTOREG,
    input  logic        FINREGWRITE,
    input  logic [1:0]  FINSIZE,
    input  logic        FINLWSIG,
    input  logic [31:0] FINlwans,
    input  logic [31:0] FINPC,
    input  logic [31:0] FINRform,
    input  logic        FINandlinlsig,
    input  logic [4:0]  FINwherereg,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    output logic        WBEN,
    output logic [4:0]  WBADDR,
    output logic [31:0] WBDATA
);

    localparam logic [31:0] LINK_OFS_C = 32'(LINKOFS);

    logic [31:0] regs_r [NREG];
    logic [31:0] load_s;
    logic [31:0] wbdata_s;
    logic        wben_s;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;

    // Pick the addressed sub-word of the aligned load data and extend it.
    function automatic logic [31:0] extract_load(
        input logic [1:0]  size,
        input logic        sgn,
        input logic [31:0] data
    );
        logic [31:0] res;
        case (size)
            2'b01:   res = {{16{sgn & data[15]}}, data[15:0]};
            2'b10:   res = {{24{sgn & data[7]}}, data[7:0]};
            default: res = data;
        endcase
        return res;
    endfunction

    // Read-port selection: zero register and reset force 0, then the optional
    // same-cycle bypass, then the array contents.
    function automatic logic [31:0] select_read(
        input logic        rst_n_v,
        input logic [4:0]  ra,
        input logic [31:0] arr_val,
        input logic        wen,
        input logic [4:0]  waddr,
        input logic [31:0] wdata
    );
        logic [31:0] res;
        if (!rst_n_v) begin
            res = 32'd0;
        end else if (ra == 5'd0) begin
            res = 32'd0;
        end else if (wen && (ra == waddr)) begin
`ifdef WB_BYPASS_EN
            res = wdata;
`else
            res = arr_val;
`endif
        end else begin
            res = arr_val;
        end
        return res;
    endfunction

    // Write-back source selection; link has priority over load over ALU.
    always_comb begin
        load_s   = extract_load(FINSIZE, FINLWSIG, FINlwans);
        wbdata_s = FINRform;
        if (FINandlinlsig) begin
            wbdata_s = FINPC + LINK_OFS_C;
        end else if (FINMEMTOREG) begin
            wbdata_s = load_s;
        end else begin
            wbdata_s = FINRform;
        end
        wben_s = FINREGWRITE & (FINwherereg != 5'd0);
    end

    // Commit the selected value; asynchronous reset clears the whole array.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wben_s) begin
            regs_r[FINwherereg] <= wbdata_s;
        end
    end

    // Combinational decode-stage read ports.
    always_comb begin
        rd1_s = select_read(RESET, RA1, regs_r[RA1], wben_s, FINwherereg, wbdata_s);
        rd2_s = select_read(RESET, RA2, regs_r[RA2], wben_s, FINwherereg, wbdata_s);
    end

    assign RD1    = rd1_s;
    assign RD2    = rd2_s;
    assign WBEN   = wben_s;
    assign WBADDR = FINwherereg;
    assign WBDATA = wbdata_s;

endmodule
